// File: rtl/fifo_flow_ctrl.sv
// fifo_flow_ctrl: synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// a registered read port with a one-cycle valid strobe.
module fifo_flow_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [ADDRESS_WIDTH:0]   th_almost_full,
  input  logic [ADDRESS_WIDTH:0]   th_almost_empty,
  input  logic                     err_clr,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     outEmpty,
  output logic                     outFull,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   fill_count,
  output logic                     errorFull,
  output logic                     errorEmpty
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDRESS_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
  logic                     data_valid_q, data_valid_d;
  logic                     err_full_q, err_full_d;
  logic                     err_empty_q, err_empty_d;

  logic empty_c, full_c, rd_ok_c, wr_ok_c, ovf_c, udf_c;

  // Occupancy decodes and accept/error qualification for this cycle
  always_comb begin
    empty_c = (count_q == CNT_W'(0));
    full_c  = (count_q == CNT_W'(DEPTH));
    rd_ok_c = en & rd & ~empty_c;
    // a full FIFO still takes a write when a read frees a slot the same edge
    wr_ok_c = en & wr & (~full_c | rd_ok_c);
    ovf_c   = en & wr & full_c & ~rd_ok_c;
    udf_c   = en & rd & empty_c;
  end

  // Next-state for pointers, count, read port and sticky errors
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    err_full_d   = err_full_q;
    err_empty_d  = err_empty_q;

    if (wr_ok_c) begin
      wptr_d = wptr_q + ADDRESS_WIDTH'(1);
    end
    if (rd_ok_c) begin
      rptr_d       = rptr_q + ADDRESS_WIDTH'(1);
      data_out_d   = mem_q[rptr_q];
      data_valid_d = 1'b1;
    end

    unique case ({wr_ok_c, rd_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // clear first so that a coincident new error takes priority
    if (en && err_clr) begin
      err_full_d  = 1'b0;
      err_empty_d = 1'b0;
    end
    if (ovf_c) err_full_d  = 1'b1;
    if (udf_c) err_empty_d = 1'b1;
  end

  // Control and read-port registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      err_full_q   <= 1'b0;
      err_empty_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      err_full_q   <= err_full_d;
      err_empty_q  <= err_empty_d;
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem_q[wptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign fill_count   = count_q;
  assign errorFull    = err_full_q;
  assign errorEmpty   = err_empty_q;
  assign outEmpty     = empty_c;
  assign outFull      = full_c;
  assign almost_full  = (count_q >= th_almost_full);
  assign almost_empty = (count_q <= th_almost_empty);

endmodule

// File: doc/fifo_flow_ctrl.md
# fifo_flow_ctrl

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow protection, sticky error flags with software clear, and a registered read port with a valid strobe. It is the next-generation buffer for the datapath, placed between a producer and a consumer on the same clock. The almost-full and almost-empty flags drive upstream pause and downstream request logic.

## Interface
- DATA_WIDTH, 8, width of each stored word
- ADDRESS_WIDTH, 3, pointer width; depth DEPTH = 2**ADDRESS_WIDTH
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  block enable; when 0 the block holds all state
- wr  in  1  write request
- rd  in  1  read request
- data_in  in  DATA_WIDTH  write data
- th_almost_full  in  ADDRESS_WIDTH+1  almost-full threshold, in words
- th_almost_empty  in  ADDRESS_WIDTH+1  almost-empty threshold, in words
- err_clr  in  1  clears both sticky error flags
- data_out  out  DATA_WIDTH  registered read data
- data_valid  out  1  one-cycle strobe: data_out updated this cycle
- outEmpty  out  1  count == 0
- outFull  out  1  count == DEPTH
- almost_full  out  1  count >= th_almost_full
- almost_empty  out  1  count <= th_almost_empty
- fill_count  out  ADDRESS_WIDTH+1  words currently stored, 0..DEPTH
- errorFull  out  1  sticky: write attempted while full
- errorEmpty  out  1  sticky: read attempted while empty

## Operation
- Reset (reset=0, asynchronous): pointers and count go to 0. data_out=0, data_valid=0, outEmpty=1, outFull=0, errorFull=0, errorEmpty=0. almost_empty=1 and almost_full=(th_almost_full==0), both derived combinationally from count. Memory contents are not reset.
- Storage: DEPTH x DATA_WIDTH array. Write pointer and read pointer are ADDRESS_WIDTH bits wide and wrap modulo DEPTH. Occupancy is held in a separate ADDRESS_WIDTH+1 bit counter.
- Accepted write (wr=1, en=1, and either not full or rd accepted in the same cycle): mem[wptr] <= data_in, then wptr+1.
- Accepted read (rd=1, en=1, not empty): data_out <= mem[rptr], then rptr+1, and data_valid=1 on the next cycle.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither.
- Write while full, no read: word dropped, wptr unchanged, errorFull <= 1.
- Write while full with read: both are accepted and count stays DEPTH.
- Read while empty: ignored; data_out is held, data_valid=0, errorEmpty <= 1. This applies even if wr=1 in the same cycle. There is no write-to-read bypass; the write is still accepted and count becomes 1.
- errorFull and errorEmpty stay set until err_clr=1 or reset. If err_clr and a new error occur in the same cycle, the new error wins (flag = 1).
- en=0: wr, rd and err_clr are ignored. No flag changes, data_out is held, data_valid=0.
- Flags are combinational decodes of the registered count and the threshold inputs. Thresholds may change at any time; the flags follow in the same cycle.

## Timing
- Write-to-visible latency: a word written at edge N updates outEmpty and fill_count after edge N. It can be read with rd asserted in cycle N+1; its data appears on data_out after that edge.
- Read latency: 1 cycle. rd sampled at edge N produces data_out and data_valid=1 after edge N. data_valid lasts exactly one cycle per accepted read.
- Back-to-back reads and writes are allowed every cycle; throughput is 1 word/cycle in each direction.
- Error flags assert the cycle after the offending edge.
- Reset deassertion is synchronised externally. The first operation may occur on the first rising edge after reset goes high.

## Test plan
- Reset mid-operation: fill 3 words, then pulse reset=0 between edges -> immediately fill_count=0, outEmpty=1, data_valid=0, errors=0; a following read sets errorEmpty=1.
- Fill/overflow with DEPTH=8: write 0x01..0x09 with no reads -> outFull=1 after the 8th write, errorFull=1 after the 9th, fill_count=8. Reading 8 words returns 0x01..0x08 in order; 0x09 was dropped.
- Wrap-around: loop 20 times writing one word and reading one word with offset occupancy of 3 -> data order preserved across pointer wrap, fill_count stays 3.
- Simultaneous events: when full, wr=1 and rd=1 -> count stays 8, no errorFull, output is the oldest word. When empty, wr=1 and rd=1 -> errorEmpty=1, count=1, data_valid=0.
- Thresholds: th_almost_full=6, th_almost_empty=2 -> almost_empty=1 for counts 0..2, almost_full=1 for counts 6..8. Changing th_almost_full to 4 at count 5 sets almost_full=1 in the same cycle.
- Error clear and enable: set both errors, then assert err_clr with en=0 -> errors unchanged. Assert err_clr with en=1 -> both clear next cycle. With en=0, wr and rd leave fill_count and data_out unchanged.
